// File: rtl/jt900h_busrsp_pkg.sv
// Shared types and constants for the JT900H bus responder: FSM states,
// address region codes, the open-bus value and a byte-merge helper.
package jt900h_busrsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEC   = 3'd1,
        ST_RAMRD = 3'd2,
        ST_ROMWT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_OPEN = 2'd2
    } region_e;

    localparam logic [15:0] OPEN_BUS = 16'hFFFF;

    // Replace the bytes selected by be with the matching bytes of new_w.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic [1:0]  be);
        merge_bytes = {be[1] ? new_w[15:8] : old_w[15:8],
                       be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

endpackage

// File: rtl/jt900h_busrsp_bram.sv
// Single-port work RAM with byte enables; the registered read port returns
// the word as it stands after a write made on the same edge.
module jt900h_busrsp_bram
    import jt900h_busrsp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [0:(1<<AW)-1];

    // Byte-lane write plus write-through registered read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we[1]) mem[addr][15:8] <= din[15:8];
            if (we[0]) mem[addr][7:0]  <= din[7:0];
            dout <= merge_bytes(mem[addr], din, we);
        end
    end

endmodule

// File: rtl/jt900h_busrsp.sv
// JT900H memory-side bus responder: work RAM, ROM handshake and open bus.
// Optional one-word ROM read buffer enabled by JT900H_BUSRSP_ROMBUF_EN.
module jt900h_busrsp
    import jt900h_busrsp_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [23:0] RAM_BASE  = 24'h004000,
    parameter logic [23:0] ROM_START = 24'h800000,
    parameter int          TMO_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cpu_cen,
    input  logic [23:0] ram_addr,
    input  logic [15:0] ram_din,
    input  logic [1:0]  ram_we,
    output logic [15:0] ram_dout,
    output logic        rom_cs,
    output logic [22:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        rom_ok,
    output logic        bus_err
);

    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e            state_r, state_nx;
    region_e           region_s;
    logic [TMO_W-1:0]  tmo_r;
    logic              is_read_s, tmo_last_s, rom_ack_s;
    logic              hit_s;
    logic [15:0]       buf_data_s;
    logic              bram_en_s;
    logic [1:0]        bram_we_s;
    logic [15:0]       bram_q_s;
    logic              dout_ld_s, cs_set_s, cs_clr_s, err_set_s;
    logic [15:0]       dout_nx_s;
    logic              unused_s;

    // Byte address bit 0 has no meaning on a word-wide bus
    assign unused_s   = ram_addr[0];
    assign is_read_s  = (ram_we == 2'b00);
    assign tmo_last_s = (tmo_r == TMO_LAST);
    assign rom_ack_s  = (state_r == ST_ROMWT) && rom_cs && rom_ok;

    // Address decode; the RAM window wins over the ROM range if they overlap
    always_comb begin
        if (ram_addr[23:RAM_AW+1] == RAM_BASE[23:RAM_AW+1]) begin
            region_s = REG_RAM;
        end else if (ram_addr >= ROM_START) begin
            region_s = REG_ROM;
        end else begin
            region_s = REG_OPEN;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: state_nx = ST_DEC;
            ST_DEC: begin
                case (region_s)
                    REG_RAM: state_nx = ST_RAMRD;
                    REG_ROM: begin
                        if (is_read_s && !hit_s) state_nx = ST_ROMWT;
                        else                     state_nx = ST_DONE;
                    end
                    default: state_nx = ST_DONE;
                endcase
            end
            ST_RAMRD: state_nx = ST_DONE;
            ST_ROMWT: begin
                if (rom_ack_s || tmo_last_s) state_nx = ST_DONE;
                else                         state_nx = ST_ROMWT;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the registered datapath
    always_comb begin
        bram_en_s = 1'b0;
        bram_we_s = 2'b00;
        dout_ld_s = 1'b0;
        dout_nx_s = OPEN_BUS;
        cs_set_s  = 1'b0;
        cs_clr_s  = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            ST_DEC: begin
                case (region_s)
                    REG_RAM: begin
                        bram_en_s = 1'b1;
                        bram_we_s = ram_we;
                    end
                    REG_ROM: begin
                        if (is_read_s && hit_s) begin
                            dout_ld_s = 1'b1;
                            dout_nx_s = buf_data_s;
                        end else if (is_read_s) begin
                            cs_set_s = 1'b1;
                        end else begin
                            dout_ld_s = 1'b0;
                        end
                    end
                    default: dout_ld_s = 1'b1;
                endcase
            end
            ST_RAMRD: begin
                dout_ld_s = 1'b1;
                dout_nx_s = bram_q_s;
            end
            ST_ROMWT: begin
                if (rom_ack_s) begin
                    dout_ld_s = 1'b1;
                    dout_nx_s = rom_data;
                    cs_clr_s  = 1'b1;
                end else if (tmo_last_s) begin
                    dout_ld_s = 1'b1;
                    cs_clr_s  = 1'b1;
                    err_set_s = 1'b1;
                end else begin
                    dout_ld_s = 1'b0;
                end
            end
            default: dout_ld_s = 1'b0;
        endcase
    end

    // Registered outputs; cpu_cen is registered from the next state so it
    // is high exactly during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_cen  <= 1'b0;
            ram_dout <= 16'h0000;
            rom_cs   <= 1'b0;
            rom_addr <= 23'd0;
            bus_err  <= 1'b0;
            tmo_r    <= '0;
        end else begin
            cpu_cen <= (state_nx == ST_DONE);
            if (dout_ld_s) ram_dout <= dout_nx_s;
            if (cs_set_s) begin
                rom_cs   <= 1'b1;
                rom_addr <= ram_addr[23:1];
            end else if (cs_clr_s) begin
                rom_cs <= 1'b0;
            end
            if (err_set_s) bus_err <= 1'b1;
            tmo_r <= (state_r == ST_ROMWT) ? tmo_r + TMO_ONE : '0;
        end
    end

`ifdef JT900H_BUSRSP_ROMBUF_EN
    logic        buf_valid_r;
    logic [22:0] buf_addr_r;
    logic [15:0] buf_data_r;

    assign hit_s      = buf_valid_r && (buf_addr_r == ram_addr[23:1]);
    assign buf_data_s = buf_data_r;

    // Remember the last good ROM word; a timeout drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= 23'd0;
            buf_data_r  <= 16'h0000;
        end else if (rom_ack_s) begin
            buf_valid_r <= 1'b1;
            buf_addr_r  <= rom_addr;
            buf_data_r  <= rom_data;
        end else if (err_set_s) begin
            buf_valid_r <= 1'b0;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign buf_data_s = OPEN_BUS;
`endif

    jt900h_busrsp_bram #(.AW(RAM_AW)) u_bram (
        .clk  (clk),
        .en   (bram_en_s),
        .we   (bram_we_s),
        .addr (ram_addr[RAM_AW:1]),
        .din  (ram_din),
        .dout (bram_q_s)
    );

endmodule

// File: tb/tb_jt900h_busrsp.sv
// Directed bench for jt900h_busrsp (TMO_W=4); ROM buffer checks follow
// JT900H_BUSRSP_ROMBUF_EN.
module tb_jt900h_busrsp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cen;
    logic [23:0] ram_addr = 24'h0;
    logic [15:0] ram_din = 16'h0;
    logic [1:0]  ram_we = 2'b00;
    logic [15:0] ram_dout;
    logic        rom_cs;
    logic [22:0] rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        rom_ok = 1'b0;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jt900h_busrsp #(.TMO_W(4)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .bus_err(bus_err)
    );

    typedef struct {
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  we;
        int          n_ok;
        logic [15:0] rdata;
        logic [15:0] exp_dout;
        int          exp_cyc;
        bit          exp_cs;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One bus cycle; ROM acks N negedges after rom_cs is first seen (0 = never)
    task automatic do_access(input logic [23:0] a, input logic [15:0] d, input logic [1:0] w,
                             input int n_ok, input logic [15:0] rd,
                             output int cyc, output bit saw_cs, output logic [22:0] cs_addr);
        int cs_cnt;
        cs_cnt = 0; cyc = 0; saw_cs = 1'b0; cs_addr = 23'd0;
        ram_addr = a; ram_din = d; ram_we = w; rom_data = rd; rom_ok = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (rom_cs) begin
                cs_cnt++;
                saw_cs = 1'b1;
                cs_addr = rom_addr;
            end
            rom_ok = rom_cs && (n_ok != 0) && (cs_cnt >= n_ok);
            if (cpu_cen) break;
            if (cyc > 200) begin
                total++; bad++;
                $display("FAIL cpu_cen_timeout: got no pulse after %0d cycles", cyc);
                break;
            end
        end
        rom_ok = 1'b0;
    endtask

    initial begin
        int cyc;
        bit saw;
        logic [22:0] ca;
        logic [23:0] va;

        vecs[0]  = '{24'h004010, 16'hBEEF, 2'b11, 0, 16'h0000, 16'hBEEF, 3, 1'b0};
        vecs[1]  = '{24'h004010, 16'h0000, 2'b00, 0, 16'h0000, 16'hBEEF, 4, 1'b0};
        vecs[2]  = '{24'h004010, 16'h12AA, 2'b10, 0, 16'h0000, 16'h12EF, 4, 1'b0};
        vecs[3]  = '{24'h004010, 16'h0000, 2'b00, 0, 16'h0000, 16'h12EF, 4, 1'b0};
        vecs[4]  = '{24'h800002, 16'h0000, 2'b00, 5, 16'hA55A, 16'hA55A, 8, 1'b1};
        vecs[5]  = '{24'h200000, 16'h0000, 2'b00, 0, 16'h0000, 16'hFFFF, 3, 1'b0};
        vecs[6]  = '{24'h004010, 16'h0000, 2'b00, 0, 16'h0000, 16'h12EF, 4, 1'b0};
        vecs[7]  = '{24'h800010, 16'h5555, 2'b11, 1, 16'h3333, 16'h12EF, 3, 1'b0};
        vecs[8]  = '{24'h005FFE, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 4, 1'b0};
        vecs[9]  = '{24'h005FFE, 16'h7F56, 2'b01, 0, 16'h0000, 16'h0056, 4, 1'b0};
        vecs[10] = '{24'h005FFE, 16'h0000, 2'b00, 0, 16'h0000, 16'h0056, 4, 1'b0};
        vecs[11] = '{24'h006000, 16'h0000, 2'b00, 0, 16'h0000, 16'hFFFF, 3, 1'b0};
        vecs[12] = '{24'h003FFE, 16'h0000, 2'b00, 0, 16'h0000, 16'hFFFF, 3, 1'b0};
        vecs[13] = '{24'h004010, 16'h0000, 2'b00, 0, 16'h0000, 16'h12EF, 4, 1'b0};
        vecs[14] = '{24'h800004, 16'h0000, 2'b00, 1, 16'h1234, 16'h1234, 4, 1'b1};
        vecs[15] = '{24'h7FFFFE, 16'h0000, 2'b00, 0, 16'h0000, 16'hFFFF, 3, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_cpu_cen", cpu_cen, 1'b0);
        check("rst_dout", ram_dout, 16'h0000);
        check("rst_rom_cs", rom_cs, 1'b0);
        check("rst_rom_addr", rom_addr, 23'd0);
        check("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i].addr, vecs[i].din, vecs[i].we, vecs[i].n_ok, vecs[i].rdata, cyc, saw, ca);
            check($sformatf("v%0d_dout", i), ram_dout, vecs[i].exp_dout);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_rom_cs", i), saw, vecs[i].exp_cs);
            check($sformatf("v%0d_bus_err", i), bus_err, 1'b0);
            if (vecs[i].exp_cs) begin
                va = vecs[i].addr;
                check($sformatf("v%0d_rom_addr", i), ca, va[23:1]);
            end
        end

        // ROM timeout: 15 wait cycles, open-bus data, sticky error
        do_access(24'h800100, 16'h0000, 2'b00, 0, 16'h1111, cyc, saw, ca);
        check("tmo_cycles", cyc, 18);
        check("tmo_dout", ram_dout, 16'hFFFF);
        check("tmo_bus_err", bus_err, 1'b1);
        check("tmo_rom_cs_low", rom_cs, 1'b0);
        do_access(24'h004010, 16'h0000, 2'b00, 0, 16'h0000, cyc, saw, ca);
        check("tmo_sticky", bus_err, 1'b1);
        check("tmo_next_dout", ram_dout, 16'h12EF);

        // Reset while waiting for the ROM, then a stray rom_ok
        ram_addr = 24'h800200; ram_we = 2'b00; rom_ok = 1'b0;
        cyc = 0;
        while (!rom_cs && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rstwt_cs_up", rom_cs, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        ram_addr = 24'h004010;
        @(negedge clk);
        check("rstwt_rom_cs", rom_cs, 1'b0);
        check("rstwt_cpu_cen", cpu_cen, 1'b0);
        check("rstwt_dout", ram_dout, 16'h0000);
        check("rstwt_rom_addr", rom_addr, 23'd0);
        check("rstwt_bus_err", bus_err, 1'b0);
        rst = 1'b0;
        cyc = 0; saw = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (rom_cs) saw = 1'b1;
            rom_ok = (cyc == 1);
            if (cpu_cen) break;
            if (cyc > 50) begin
                total++; bad++;
                $display("FAIL rstwt_timeout: got no pulse after %0d cycles", cyc);
                break;
            end
        end
        rom_ok = 1'b0;
        check("rstwt_cycles", cyc, 3);
        check("rstwt_no_cs", saw, 1'b0);
        check("rstwt_ram_kept", ram_dout, 16'h12EF);

        do_access(24'h800002, 16'h0000, 2'b00, 2, 16'hA55A, cyc, saw, ca);
        check("rd1_dout", ram_dout, 16'hA55A);
        check("rd1_cycles", cyc, 5);
        check("rd1_cs", saw, 1'b1);
        check("rd1_rom_addr", ca, 23'h400001);
`ifdef JT900H_BUSRSP_ROMBUF_EN
        do_access(24'h800002, 16'h0000, 2'b00, 2, 16'h0BAD, cyc, saw, ca);
        check("buf_hit_dout", ram_dout, 16'hA55A);
        check("buf_hit_cycles", cyc, 3);
        check("buf_hit_no_cs", saw, 1'b0);
`else
        do_access(24'h800002, 16'h0000, 2'b00, 2, 16'h5AA5, cyc, saw, ca);
        check("rd2_dout", ram_dout, 16'h5AA5);
        check("rd2_cycles", cyc, 5);
        check("rd2_cs", saw, 1'b1);
`endif
        do_access(24'h800004, 16'h0000, 2'b00, 1, 16'h7777, cyc, saw, ca);
        check("rd3_dout", ram_dout, 16'h7777);
        check("rd3_cycles", cyc, 4);
        check("rd3_cs", saw, 1'b1);
        check("rd3_rom_addr", ca, 23'h400002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
